// File: rtl/read_d_fetch_arbiter_pkg.sv
// Shared constants and encodings for the read/D(i) ROM fetch arbiter.
package read_d_fetch_arbiter_pkg;

    localparam int unsigned READ_W = 2;
    localparam int unsigned D_W    = 8;
    localparam int unsigned ADDR_W = 8;

    // Read index -1 is encoded as all-ones and never touches real ROM data.
    localparam logic [ADDR_W-1:0] ADDR_NEG1 = 8'hff;

    typedef enum logic [READ_W-1:0] {
        SYM_A = 2'b00,
        SYM_C = 2'b01,
        SYM_G = 2'b10,
        SYM_T = 2'b11
    } sym_e;

endpackage

// File: rtl/read_d_fetch_arbiter_if.sv
// Engine request/response bus plus the ROM pins owned by the arbiter.
interface read_d_fetch_arbiter_if
    import read_d_fetch_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4
);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic [READ_W-1:0]       rsp_read;
    logic [D_W-1:0]          rsp_d;
    logic                    rsp_oob;
    logic                    rom_ce;
    logic [ADDR_W-1:0]       rom_addr;
    logic [D_W-1:0]          rom_d_i;
    logic [READ_W-1:0]       rom_read_i;

    // Engines and the ROM side.
    modport master (
        output req_valid, req_addr, rom_d_i, rom_read_i,
        input  req_ready, rsp_valid, rsp_read, rsp_d, rsp_oob, rom_ce, rom_addr
    );

    // The arbiter.
    modport slave (
        input  req_valid, req_addr, rom_d_i, rom_read_i,
        output req_ready, rsp_valid, rsp_read, rsp_d, rsp_oob, rom_ce, rom_addr
    );

endinterface

// File: rtl/read_d_fetch_arbiter_rr_arbiter.sv
// N-way round-robin picker: one-hot grant to the first eligible index at or after ptr.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]     eligible,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    int unsigned idx;
    logic        found;

    // Scan ptr, ptr+1, ... with wrap; the first eligible index wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = (32'(ptr) + i) % N;
            if (!found && eligible[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/read_d_fetch_arbiter.sv
// Round-robin sharing of the read/D(i) ROM among search engines, 2-stage pipeline.
module read_d_fetch_arbiter
    import read_d_fetch_arbiter_pkg::*;
#(
    parameter int unsigned       N_REQ     = 4,
    parameter int unsigned       ID_W      = 2,
    parameter logic [ADDR_W-1:0] ADDR_NEG1 = 8'hff
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    read_d_fetch_arbiter_if.slave       bus
);

    logic [N_REQ-1:0]  busy_q, busy_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic              s1_valid_q, s1_valid_d;
    logic [ID_W-1:0]   s1_id_q, s1_id_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [READ_W-1:0] rsp_read_q, rsp_read_d;
    logic [D_W-1:0]    rsp_d_q, rsp_d_d;
    logic              rsp_oob_q, rsp_oob_d;

    logic [N_REQ-1:0]  eligible;
    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   gnt_id;
    logic [ADDR_W-1:0] gnt_addr;
    logic              s1_oob;

    assign eligible = bus.req_valid & ~busy_q & {N_REQ{~flush}};

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (ID_W)
    ) u_rr (
        .eligible (eligible),
        .ptr      (rr_ptr_q),
        .grant    (grant)
    );

    // Encode the one-hot grant into an id and select that engine's address.
    always_comb begin
        gnt_id   = '0;
        gnt_addr = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (grant[k]) begin
                gnt_id   = ID_W'(k);
                gnt_addr = bus.req_addr[ADDR_W*k +: ADDR_W];
            end
        end
    end

    assign s1_oob = (s1_addr_q == ADDR_NEG1);

    // Next-state for pointer, busy tracking, stage 1 and the response registers.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        busy_d      = busy_q;
        s1_valid_d  = |grant;
        s1_id_d     = gnt_id;
        s1_addr_d   = gnt_addr;
        rsp_valid_d = '0;
        rsp_read_d  = '0;
        rsp_d_d     = '0;
        rsp_oob_d   = 1'b0;

        if (|grant) begin
            rr_ptr_d = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end

        if (flush) begin
            busy_d = '0;
        end else begin
            // Grant and retire never hit the same engine: a busy engine is not eligible.
            busy_d = busy_q | grant;
            if (s1_valid_q) begin
                busy_d[s1_id_q]      = 1'b0;
                rsp_valid_d[s1_id_q] = 1'b1;
                rsp_oob_d            = s1_oob;
                rsp_read_d           = s1_oob ? '0 : bus.rom_read_i;
                rsp_d_d              = s1_oob ? '0 : bus.rom_d_i;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            busy_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s1_addr_q   <= '0;
            rsp_valid_q <= '0;
            rsp_read_q  <= '0;
            rsp_d_q     <= '0;
            rsp_oob_q   <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            busy_q      <= busy_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            s1_addr_q   <= s1_addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_read_q  <= rsp_read_d;
            rsp_d_q     <= rsp_d_d;
            rsp_oob_q   <= rsp_oob_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.rom_ce    = s1_valid_q;
    assign bus.rom_addr  = s1_valid_q ? s1_addr_q : '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_read  = rsp_read_q;
    assign bus.rsp_d     = rsp_d_q;
    assign bus.rsp_oob   = rsp_oob_q;

endmodule

// File: doc/read_d_fetch_arbiter.md
Name: read_d_fetch_arbiter

Overview:
- Shares the single read-symbol/D(i) ROM port among N_REQ backtracking search engines.
- Each engine requests one read index i, returning the read symbol (2 bits: 00 A, 01 C, 10 G, 11 T) plus search bound D(i) (8 bits).
- Round-robin arbitration with a 2-stage registered pipeline: one ROM access per cycle, at most one outstanding request per engine.
- Sits between the search engines and the combinational read/D ROM, and owns the ROM ce/addr pins.

Parameters:
- N_REQ, 4, number of requesting search engines (2..8).
- ID_W, 2, requester id width; equals clog2(N_REQ), minimum 1.
- ADDR_NEG1, 8'hff, address encoding of index -1 (out of range).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; drop all in-flight requests.
- req_valid  in  N_REQ  per-engine request.
- req_addr  in  N_REQ*8  packed read index per engine; slot k is bits [8k+7:8k].
- req_ready  out  N_REQ  one-hot grant for this cycle.
- rsp_valid  out  N_REQ  one-hot response strobe.
- rsp_read  out  2  read symbol.
- rsp_d  out  8  search bound D(i).
- rsp_oob  out  1  response belongs to an index -1 request.
- rom_ce  out  1  ROM enable.
- rom_addr  out  8  ROM address.
- rom_d_i  in  8  ROM D(i) data (combinational).
- rom_read_i  in  2  ROM symbol data (combinational).

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs 0; busy[] = 0; rr_ptr = 0; stage valids = 0.
  - Reset mid-transaction discards in-flight work; no response is issued for it.
- Eligibility: eligible[k] = req_valid[k] & ~busy[k] & ~flush.
- Arbitration (combinational):
  - req_ready = one-hot first eligible index searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., N_REQ-1, 0, ...).
  - All zero when none is eligible.
- Handshake:
  - Transfer occurs when req_valid[k] & req_ready[k].
  - req_ready never depends on anything later in the cycle than req_valid.
  - Engines hold req_valid and req_addr stable until transfer.
- On transfer of k at edge E0:
  - s1_valid=1, s1_id=k, s1_addr=req_addr[k].
  - busy[k] set.
  - rr_ptr = (k+1) mod N_REQ.
  - rr_ptr is unchanged when there is no transfer.
- Stage 1 (cycle after E0): rom_ce = s1_valid, rom_addr = s1_valid ? s1_addr : 0.
- Edge E1 captures the ROM outputs into the response registers:
  - rsp_valid[s1_id] = 1 for exactly one cycle.
  - rsp_read/rsp_d = 0 when s1_addr==ADDR_NEG1, else the ROM outputs.
  - rsp_oob = (s1_addr==ADDR_NEG1).
  - busy[s1_id] cleared.
- Latency: response is visible in the cycle following E1, i.e. 2 edges after acceptance.
- Throughput: 1 request/cycle aggregate.
- Re-request: an engine may re-request in the same cycle its rsp_valid is high (busy is already clear).
- Simultaneous set/clear of busy for one engine cannot occur, because busy blocks a new grant.
- Idle: when no response is issued, rsp_read/rsp_d/rsp_oob hold 0.
- flush (sampled at an edge):
  - clears s1_valid, rsp_valid, and all busy bits.
  - no grant is made in a flush cycle.
  - rr_ptr is kept.
- Every registered output resets via rst_n.

Decomposition:
- Shared package holds:
  - symbol encodings SYM_A=2'b00, SYM_C=2'b01, SYM_G=2'b10, SYM_T=2'b11;
  - ADDR_NEG1=8'hff;
  - read/D entry widths (READ_W=2, D_W=8).
- One sub-module, rr_arbiter: a parameterized N-way round-robin priority picker, taking (eligible, rr_ptr) and producing a one-hot grant.
- The pipeline and busy tracking stay in the top module.

Test Plan:
- Bench ROM model: mem[a] = {a[1:0], a^8'h5A}.
- Single request: engine 2 requests addr 8'h10 → req_ready[2] the same cycle; 2 edges later rsp_valid=4'b0100, rsp_read=2'b00, rsp_d=8'h4A, rsp_oob=0, single cycle.
- Out-of-range: engine 0 requests addr 8'hff → rsp_valid[0] after 2 edges, rsp_d=0, rsp_read=0, rsp_oob=1.
- Fairness: all 4 engines request continuously, re-requesting on response → grant order 0,1,2,3,0,1,... with one grant/cycle once steady; no engine is granted twice while busy.
- Back-pressure: engine 1 holds req_valid during its outstanding request → req_ready[1]=0 until rsp_valid[1] pulses; the next grant to 1 is no earlier than that cycle.
- Flush: grant engine 3 at addr 8'h07, assert flush the next cycle → no rsp_valid, busy cleared; engine 3 is re-grantable in the cycle after flush.
- Async reset: drop rst_n between acceptance and response → all outputs 0 immediately, no response after release, first grant after release goes to engine 0.
